// File: rtl/ram_responder_pkg.sv
// Shared definitions for the RAM bus responder: pin positions, state encoding, address helpers.
// Pin and state values are also what the mobo side decodes, so they must not move.
package ram_responder_pkg;

  localparam int RAM_READ_PIN  = 0;
  localparam int RAM_WRITE_PIN = 1;
  localparam int RAM_ACK_PIN   = 0;
  localparam int RAM_BUSY_PIN  = 1;
  localparam int RAM_ERR_PIN   = 2;

  typedef enum logic [1:0] {
    RS_IDLE = 2'd0,
    RS_WAIT = 2'd1,
    RS_EXEC = 2'd2,
    RS_DONE = 2'd3
  } rs_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } ram_op_t;

  // Word aligned and inside [base, base + 4*2**aw); widened to 64 bits so large windows do not wrap.
  function automatic logic addr_in_window(input logic [31:0] a, input logic [31:0] base, input int aw);
    logic [63:0] off;
    logic [63:0] span;
    off  = {32'd0, a - base};
    span = 64'd1 << (aw + 2);
    return (a[1:0] == 2'b00) && (a >= base) && (off < span);
  endfunction

  function automatic logic [31:0] word_offset(input logic [31:0] a, input logic [31:0] base);
    return (a - base) >> 2;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port 32-bit word storage, one-cycle registered read, write-first.
// Contents and read register are deliberately left unreset.
module ram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] index,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
      rdata      <= wdata;
    end else begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side end of the RAM bus: four-phase request/ack with WAIT_CYCLES wait states.
// Request rise to ACK rise is WAIT_CYCLES+2 edges; ACK is held until both request pins drop.
module ram_responder
  import ram_responder_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_ctrl_in,
  output logic [31:0] ram_ctrl_out,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  localparam int               CNT_W    = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  rs_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       lat_addr;
  logic [31:0]       lat_data;
  ram_op_t           lat_op;
  logic              ack;
  logic              busy;
  logic              err;
  logic              rd_req;
  logic              wr_req;
  logic              addr_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_index;
  logic [31:0]       mem_rdata;
  logic              unused_pins;

  assign rd_req      = ram_ctrl_in[RAM_READ_PIN];
  assign wr_req      = ram_ctrl_in[RAM_WRITE_PIN];
  assign unused_pins = ^ram_ctrl_in;
  assign addr_ok     = addr_in_window(lat_addr, BASE_ADDR, ADDR_W);
  assign mem_we      = (state == RS_EXEC) && (lat_op == OP_WRITE) && addr_ok;

  // Index follows the live address while idle so the array read is already
  // in flight at the accept edge; with zero wait states EXEC can then register it directly.
  assign mem_index = ADDR_W'(word_offset((state == RS_IDLE) ? addr : lat_addr, BASE_ADDR));

  ram_array #(
    .ADDR_W(ADDR_W)
  ) u_ram_array (
    .clk  (clk),
    .we   (mem_we),
    .index(mem_index),
    .wdata(lat_data),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= RS_IDLE;
      cnt      <= '0;
      lat_addr <= '0;
      lat_data <= '0;
      lat_op   <= OP_READ;
      ack      <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      data_out <= '0;
    end else begin
      case (state)
        RS_IDLE: begin
          if (rd_req ^ wr_req) begin
            lat_addr <= addr;
            lat_data <= data_in;
            lat_op   <= wr_req ? OP_WRITE : OP_READ;
            cnt      <= CNT_LOAD;
            busy     <= 1'b1;
            state    <= (WAIT_CYCLES == 0) ? RS_EXEC : RS_WAIT;
          end else if (rd_req && wr_req) begin
            err   <= 1'b1;
            ack   <= 1'b1;
            state <= RS_DONE;
          end
        end
        RS_WAIT: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            state <= RS_EXEC;
          end
        end
        RS_EXEC: begin
          busy  <= 1'b0;
          ack   <= 1'b1;
          state <= RS_DONE;
          if (!addr_ok) begin
            err      <= 1'b1;
            data_out <= '0;
          end else if (lat_op == OP_READ) begin
            data_out <= mem_rdata;
          end else begin
            data_out <= '0;
          end
        end
        RS_DONE: begin
          if (!rd_req && !wr_req) begin
            ack      <= 1'b0;
            err      <= 1'b0;
            data_out <= '0;
            state    <= RS_IDLE;
          end
        end
        default: state <= RS_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_ctrl_out               = '0;
    ram_ctrl_out[RAM_ACK_PIN]  = ack;
    ram_ctrl_out[RAM_BUSY_PIN] = busy;
    ram_ctrl_out[RAM_ERR_PIN]  = err;
  end

endmodule

// File: tb/tb_ram_responder.sv
// Drives two responders (2 and 0 wait states) with identical requests and checks each
// against a word-array model and the expected handshake timing.
module tb_ram_responder;

  localparam int W_A = 2;
  localparam int W_B = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ram_ctrl_in;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] ctrl_a, dout_a, ctrl_b, dout_b;

  int total  = 0;
  int passed = 0;

  logic [31:0] mem_a [int];
  logic [31:0] mem_b [int];

  always #5 clk = ~clk;

  ram_responder #(.ADDR_W(10), .WAIT_CYCLES(W_A), .BASE_ADDR(32'h0)) dut_a (
    .clk(clk), .rst(rst), .ram_ctrl_in(ram_ctrl_in), .ram_ctrl_out(ctrl_a),
    .addr(addr), .data_in(data_in), .data_out(dout_a)
  );

  ram_responder #(.ADDR_W(10), .WAIT_CYCLES(W_B), .BASE_ADDR(32'h0)) dut_b (
    .clk(clk), .rst(rst), .ram_ctrl_in(ram_ctrl_in), .ram_ctrl_out(ctrl_b),
    .addr(addr), .data_in(data_in), .data_out(dout_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Status word: ACK bit 0, BUSY bit 1, ERR bit 2.
  function automatic logic [31:0] status(input logic a, input logic b, input logic e);
    return {29'd0, e, b, a};
  endfunction

  function automatic bit is_err(input logic rd, input logic wr, input logic [31:0] a);
    return (rd && wr) || (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input int hold, input string tag);
    bit          e;
    int          idx;
    logic [31:0] ea, eb;
    int          edges, lat_a, lat_b, busy_a, busy_b;
    bit          got_a, got_b;
    e   = is_err(rd, wr, a);
    idx = int'(a >> 2);
    ea  = 32'd0;
    eb  = 32'd0;
    if (!e && rd) begin
      ea = mem_a[idx];
      eb = mem_b[idx];
    end
    if (!e && wr) begin
      mem_a[idx] = d;
      mem_b[idx] = d;
    end
    @(posedge clk);
    #1;
    ram_ctrl_in = {30'd0, wr, rd};
    addr        = a;
    data_in     = d;
    edges = 0; lat_a = 0; lat_b = 0; busy_a = 0; busy_b = 0; got_a = 0; got_b = 0;
    while (!(got_a && got_b) && edges < 16) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!got_a) begin
        if (ctrl_a[0]) begin got_a = 1; lat_a = edges; end
        else if (ctrl_a[1]) busy_a++;
      end
      if (!got_b) begin
        if (ctrl_b[0]) begin got_b = 1; lat_b = edges; end
        else if (ctrl_b[1]) busy_b++;
      end
    end
    check({tag, " lat_a"}, lat_a, (rd && wr) ? 1 : W_A + 2);
    check({tag, " lat_b"}, lat_b, (rd && wr) ? 1 : W_B + 2);
    check({tag, " busy_a"}, busy_a, (rd && wr) ? 0 : W_A + 1);
    check({tag, " busy_b"}, busy_b, (rd && wr) ? 0 : W_B + 1);
    check({tag, " st_a"}, ctrl_a, status(1'b1, 1'b0, e));
    check({tag, " st_b"}, ctrl_b, status(1'b1, 1'b0, e));
    check({tag, " dout_a"}, dout_a, ea);
    check({tag, " dout_b"}, dout_b, eb);
    // Wiggle addr/data while the request is held: nothing may change.
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      addr    = $urandom;
      data_in = $urandom;
      @(negedge clk);
      check({tag, " hold st_a"}, ctrl_a, status(1'b1, 1'b0, e));
      check({tag, " hold st_b"}, ctrl_b, status(1'b1, 1'b0, e));
      check({tag, " hold dout_a"}, dout_a, ea);
      check({tag, " hold dout_b"}, dout_b, eb);
    end
    @(posedge clk);
    #1;
    ram_ctrl_in = 32'd0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " drop st_a"}, ctrl_a, 32'd0);
    check({tag, " drop st_b"}, ctrl_b, 32'd0);
    check({tag, " drop dout_a"}, dout_a, 32'd0);
    check({tag, " drop dout_b"}, dout_b, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    int          r, op;
    ram_ctrl_in = 32'd0;
    addr        = 32'd0;
    data_in     = 32'd0;
    rst         = 1'b1;
    #2 rst = 1'b0;
    #20;
    check("reset st_a", ctrl_a, 32'd0);
    check("reset st_b", ctrl_b, 32'd0);
    check("reset dout_a", dout_a, 32'd0);
    check("reset dout_b", dout_b, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 0, "wr10");
    access(1'b1, 1'b0, 32'h10, 32'h0, 0, "rd10");
    access(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 0, "wr20");
    access(1'b1, 1'b1, 32'h20, 32'h1111_1111, 0, "both20");
    access(1'b1, 1'b0, 32'h20, 32'h0, 0, "rd20");
    access(1'b1, 1'b0, 32'h13, 32'h0, 0, "rd13");
    access(1'b1, 1'b0, 32'h1000, 32'h0, 0, "rd1000");
    access(1'b0, 1'b1, 32'h1000, 32'h7777_7777, 0, "wr1000");
    access(1'b1, 1'b0, 32'h0FFC, 32'h0, 0, "rdffc_pre");
    access(1'b0, 1'b1, 32'h0, 32'h1, 0, "wr0");
    access(1'b1, 1'b0, 32'h0, 32'h0, 0, "rd0");
    access(1'b1, 1'b0, 32'h10, 32'h0, 5, "hold10");

    // Reset during the wait states of dut_a; dut_b (no waits) has already committed.
    access(1'b0, 1'b1, 32'h40, 32'h1234_5678, 0, "wr40");
    @(posedge clk);
    #1;
    ram_ctrl_in = 32'h2;
    addr        = 32'h40;
    data_in     = 32'h5555_5555;
    @(posedge clk);
    @(posedge clk);
    mem_b[16] = 32'h5555_5555;
    #1;
    check("pre-rst st_a", ctrl_a, status(1'b0, 1'b1, 1'b0));
    check("pre-rst st_b", ctrl_b, status(1'b1, 1'b0, 1'b0));
    #1 rst = 1'b0;
    #1;
    check("mid-rst st_a", ctrl_a, 32'd0);
    check("mid-rst st_b", ctrl_b, 32'd0);
    check("mid-rst dout_a", dout_a, 32'd0);
    check("mid-rst dout_b", dout_b, 32'd0);
    ram_ctrl_in = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    access(1'b1, 1'b0, 32'h40, 32'h0, 0, "rd40");

    // Randomized traffic over a pre-initialised pool of words.
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 1'b1, 32'h100 + 32'(i * 4), $urandom, 0, "init");
    end
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(1, 3));
      else if (r == 1) a = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFC : 32'h1000 + 32'($urandom_range(0, 63) * 4);
      else             a = 32'h100 + 32'($urandom_range(0, 15) * 4);
      d  = $urandom;
      op = $urandom_range(0, 7);
      if (op == 0)      access(1'b1, 1'b1, a, d, $urandom_range(0, 2), "rnd both");
      else if (op <= 3) access(1'b0, 1'b1, a, d, $urandom_range(0, 2), "rnd wr");
      else              access(1'b1, 1'b0, a, d, $urandom_range(0, 2), "rnd rd");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side end of the motherboard RAM bus. Receives read/write requests on ram_ctrl_in, addr and data_in, and completes them against an internal word array.
- Returns an ack, busy and error status on ram_ctrl_out, plus read data on data_out.
- Inserts a programmable number of wait states per access. Uses a four-phase handshake so the mobo state machine can step through its states safely.

Parameters:
- ADDR_W, 10, word-address width; array depth = 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2, wait states between request acceptance and ack (0 allowed).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to the 2**(ADDR_W+2) window.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- ram_ctrl_in  input  32  request pins from mobo: bit `RAM_READ_PIN = read request, bit `RAM_WRITE_PIN = write request, other bits ignored.
- ram_ctrl_out  output  32  status pins to mobo: bit `RAM_ACK_PIN, bit `RAM_BUSY_PIN, bit `RAM_ERR_PIN; all other bits 0.
- addr  input  32  byte address from mobo, sampled at acceptance.
- data_in  input  32  write data from mobo, sampled at acceptance.
- data_out  output  32  read data to mobo, valid while ACK=1 for a read.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=RS_IDLE, wait counter=0, ram_ctrl_out=0, data_out=0.
  - Array contents are NOT cleared.
  - Reset mid-access aborts the access; no write is committed unless the commit edge already occurred.
- Request pins are active-high and level-sensitive.
- States:
  - RS_IDLE: BUSY=0, ACK=0.
    - If exactly one of READ/WRITE is 1: latch addr, data_in and op, load counter=WAIT_CYCLES, go to RS_WAIT. If WAIT_CYCLES=0, go directly to RS_EXEC.
    - If both are 1: latch ERR=1 and go to RS_DONE; the array is not touched.
  - RS_WAIT: BUSY=1. Decrement counter each cycle; when counter==1, go to RS_EXEC. Request inputs are ignored here.
  - RS_EXEC (one cycle): BUSY=1, then go to RS_DONE.
    - Range check: latched addr[1:0]!=0, or addr outside [BASE_ADDR, BASE_ADDR+4*2**ADDR_W), gives ERR=1 and no array access.
    - Otherwise, write: mem[index]<=data. Read: register mem[index] into data_out.
  - RS_DONE: ACK=1, BUSY=0, ERR as latched, data_out held.
    - Stay while READ|WRITE is still 1.
    - When both are 0, go to RS_IDLE next edge, clearing ACK, ERR and data_out to 0.
- Word index = (addr-BASE_ADDR)>>2, truncated to ADDR_W bits after the range check.
- Latency, request rise to ACK rise: WAIT_CYCLES+2 edges (accept edge, WAIT_CYCLES waits, EXEC edge).
- Back-to-back: a new request is accepted no earlier than one cycle after the previous request drops (one RS_IDLE cycle is mandatory).
- Request changes (op, addr or data) after acceptance are ignored. Only the latched values are used.
- Read-after-write to the same word returns the new data.
- data_out is 0 for writes and errored accesses.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- control_pins.v gains `RAM_WRITE_PIN, `RAM_ACK_PIN, `RAM_BUSY_PIN and `RAM_ERR_PIN, alongside the existing `RAM_READ_PIN. Bit positions are 0, 1, 0, 1, 2.
- New ram_states.v holds `RS_IDLE, `RS_WAIT, `RS_EXEC and `RS_DONE. It is shared with mobo so it can decode bus status consistently.
- Sub-module ram_array:
  - Single-port synchronous 32-bit x 2**ADDR_W storage.
  - Ports: clk, we, index, wdata, rdata.
  - One-cycle registered read, write-first.
  - No reset on contents.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to addr 32'h10 (WAIT_CYCLES=2) -> ACK rises 4 edges after WRITE rises, BUSY high for the 3 cycles before it, ERR=0. After WRITE drops, ACK=0 next edge. Then read 32'h10 -> data_out=32'hDEAD_BEEF with ACK=1.
- READ and WRITE both high at addr 32'h20 -> ACK=1 with ERR=1, data_out=0. A subsequent read of 32'h20 returns the prior contents (unchanged).
- Read at misaligned 32'h13, and at 32'h1000 (ADDR_W=10, first out-of-range word) -> ERR=1, ACK=1, data_out=0.
- WAIT_CYCLES=0: WRITE 32'h1 at 32'h0, then immediately READ 32'h0 after one idle cycle -> ACK latency 2 edges, data_out=32'h1.
- Assert rst=0 while in RS_WAIT of a write of 32'h5555_5555 to 32'h40 -> outputs 0 immediately, without waiting for a clock edge. A read of 32'h40 after reset returns the previous value.
- Hold READ high across RS_DONE for 5 cycles while changing addr -> ACK stays 1, data_out unchanged, no new access started. RS_IDLE is entered only after READ drops.
